// File: rtl/imem_uart_loader.sv
// imem_uart_loader: UART boot loader for the single-cycle MIPS core.
// Receives a framed program over an 8N1 serial line, writes it word by word
// into instruction memory, and holds the core in reset until the load is done.
// Frame: 0xA5, LEN_LO, LEN_HI, then LEN words of 4 little-endian bytes.
// Optional build macro IMEM_LOADER_CHECKSUM_EN: the frame carries a trailing
// XOR checksum byte over LEN_LO, LEN_HI and every data byte.
module imem_uart_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  uart_rx,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_rst_n,
    output logic                  load_busy,
    output logic                  load_done,
    output logic                  load_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [ADDR_WIDTH:0] IDX_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE, S_ERROR
    } state_t;

    // State entered once the last data word (or an empty body) is consumed.
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t AFTER_BODY = S_CHK;
`else
    localparam state_t AFTER_BODY = S_DONE;
`endif

    logic            rx_meta_reg, rx_sync_reg, rx_prev_reg;
    rx_state_t       rx_state_reg;
    logic [CW-1:0]   rx_cnt_reg;
    logic [2:0]      rx_bit_reg;
    logic [7:0]      rx_shift_reg;
    logic            rx_valid_reg, rx_ferr_reg;

    state_t                state_reg, state_next;
    logic [15:0]           len_reg;
    logic [1:0]            byte_cnt_reg;
    logic [23:0]           word_buf_reg;
    logic [ADDR_WIDTH:0]   word_idx_reg;
    logic                  imem_we_reg, cpu_rst_n_reg;
    logic [ADDR_WIDTH-1:0] imem_addr_reg;
    logic [31:0]           imem_wdata_reg;

    logic [15:0] len_full;
    logic        last_word;

    assign len_full  = {rx_shift_reg, len_reg[7:0]};
    // word_idx_reg is the index of the word being completed, so +1 gives words done.
    assign last_word = (17'(word_idx_reg) + 17'd1) == {1'b0, len_reg};

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
            rx_prev_reg <= 1'b1;
        end else begin
            rx_meta_reg <= uart_rx;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;
        end
    end

    // UART receiver: centre-samples start, 8 data bits LSB first, and stop bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state_reg <= RX_IDLE;
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_shift_reg <= '0;
            rx_valid_reg <= 1'b0;
            rx_ferr_reg  <= 1'b0;
        end else begin
            rx_valid_reg <= 1'b0;
            rx_ferr_reg  <= 1'b0;
            case (rx_state_reg)
                RX_IDLE: begin
                    if (rx_prev_reg && !rx_sync_reg) begin
                        rx_state_reg <= RX_START;
                        rx_cnt_reg   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt_reg == HALF_LAST) begin
                        rx_cnt_reg   <= '0;
                        rx_bit_reg   <= '0;
                        // Line high again at mid start bit: glitch, not a frame.
                        rx_state_reg <= rx_sync_reg ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + CNT_ONE;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_reg == BIT_LAST) begin
                        rx_cnt_reg   <= '0;
                        rx_shift_reg <= {rx_sync_reg, rx_shift_reg[7:1]};
                        rx_bit_reg   <= rx_bit_reg + 3'd1;
                        if (rx_bit_reg == 3'd7) rx_state_reg <= RX_STOP;
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + CNT_ONE;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_reg == BIT_LAST) begin
                        rx_cnt_reg   <= '0;
                        rx_state_reg <= RX_IDLE;
                        if (rx_sync_reg) rx_valid_reg <= 1'b1;
                        else             rx_ferr_reg  <= 1'b1;
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + CNT_ONE;
                    end
                end
                default: rx_state_reg <= RX_IDLE;
            endcase
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] chk_reg;

    // Running XOR over length and data bytes; restarts on every header.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chk_reg <= '0;
        end else if (rx_valid_reg) begin
            case (state_reg)
                S_IDLE, S_DONE:             chk_reg <= '0;
                S_LEN_LO, S_LEN_HI, S_DATA: chk_reg <= chk_reg ^ rx_shift_reg;
                default: ;
            endcase
        end
    end
`endif

    // Loader FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_reg <= S_IDLE;
        else        state_reg <= state_next;
    end

    // Loader FSM next-state logic, advanced by received bytes.
    always_comb begin
        state_next = state_reg;
        if (rx_ferr_reg && state_reg != S_IDLE) begin
            state_next = S_ERROR;
        end else if (rx_valid_reg) begin
            case (state_reg)
                S_IDLE:   if (rx_shift_reg == 8'hA5) state_next = S_LEN_LO;
                S_LEN_LO: state_next = S_LEN_HI;
                S_LEN_HI: begin
                    if ({1'b0, len_full} > MAX_WORDS) state_next = S_ERROR;
                    else if (len_full == 16'd0)        state_next = AFTER_BODY;
                    else                               state_next = S_DATA;
                end
                S_DATA:   if (byte_cnt_reg == 2'd3 && last_word) state_next = AFTER_BODY;
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHK:    state_next = (rx_shift_reg == chk_reg) ? S_DONE : S_ERROR;
`endif
                S_DONE:   if (rx_shift_reg == 8'hA5) state_next = S_LEN_LO;
                default: ;
            endcase
        end
    end

    // Status outputs decoded from the current state.
    always_comb begin
        load_busy = 1'b0;
        load_done = 1'b0;
        load_err  = 1'b0;
        case (state_reg)
            S_LEN_LO, S_LEN_HI, S_DATA: load_busy = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK:   load_busy = 1'b1;
`endif
            S_DONE:  load_done = 1'b1;
            S_ERROR: load_err  = 1'b1;
            default: ;
        endcase
    end

    // Datapath: length latch, word assembly, memory write port, core reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_reg        <= '0;
            byte_cnt_reg   <= '0;
            word_buf_reg   <= '0;
            word_idx_reg   <= '0;
            imem_we_reg    <= 1'b0;
            imem_addr_reg  <= '0;
            imem_wdata_reg <= '0;
            cpu_rst_n_reg  <= 1'b0;
        end else begin
            imem_we_reg   <= 1'b0;
            // Release only once DONE has been held for a cycle; drop on reload.
            cpu_rst_n_reg <= (state_reg == S_DONE) && (state_next == S_DONE);
            if (rx_valid_reg) begin
                case (state_reg)
                    S_IDLE, S_DONE: begin
                        if (rx_shift_reg == 8'hA5) begin
                            byte_cnt_reg <= '0;
                            word_idx_reg <= '0;
                        end
                    end
                    S_LEN_LO: len_reg[7:0]  <= rx_shift_reg;
                    S_LEN_HI: len_reg[15:8] <= rx_shift_reg;
                    S_DATA: begin
                        byte_cnt_reg <= byte_cnt_reg + 2'd1;
                        word_buf_reg <= {rx_shift_reg, word_buf_reg[23:8]};
                        if (byte_cnt_reg == 2'd3) begin
                            imem_we_reg    <= 1'b1;
                            imem_addr_reg  <= word_idx_reg[ADDR_WIDTH-1:0];
                            imem_wdata_reg <= {rx_shift_reg, word_buf_reg};
                            word_idx_reg   <= word_idx_reg + IDX_ONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign imem_we    = imem_we_reg;
    assign imem_addr  = imem_addr_reg;
    assign imem_wdata = imem_wdata_reg;
    assign cpu_rst_n  = cpu_rst_n_reg;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Testbench for imem_uart_loader: directed frames driven over the serial line,
// writes captured by a monitor and compared to hand-computed expectations.
module tb_imem_uart_loader;
    localparam int CPB = 4;
    localparam int AW  = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          uart_rx = 1'b1;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_rst_n, load_busy, load_done, load_err;

    always #5 clk = ~clk;

    imem_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_rx    (uart_rx),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst_n  (cpu_rst_n),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    typedef struct {
        logic [127:0] bytes;   // first byte sent is the most significant used byte
        int           nbytes;
        int           bad;     // index of byte sent with a low stop bit, -1 none
        int           nwr;
        logic [63:0]  words;   // word0 in [31:0], word1 in [63:32]
        logic         done;
        logic         err;
    } vec_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam int NV = 7;
`else
    localparam int NV = 6;
`endif

    vec_t        v [NV];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          wr_count = 0;
    logic [AW-1:0] wr_addr [16];
    logic [31:0] wr_data [16];
    logic        prev_done = 1'b0, prev_cpu = 1'b0;
    int          done_rise = -1, cpu_rise = -1;

    // Monitor: capture every write strobe and the rising edges of done / core reset.
    always @(negedge clk) begin
        cyc++;
        if (imem_we) begin
            if (wr_count < 16) begin
                wr_addr[wr_count] = imem_addr;
                wr_data[wr_count] = imem_wdata;
            end
            wr_count++;
        end
        if (load_done && !prev_done) done_rise = cyc;
        if (cpu_rst_n && !prev_cpu)  cpu_rise  = cyc;
        prev_done = load_done;
        prev_cpu  = cpu_rst_n;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (CPB) @(negedge clk);
        $display("tx byte=%02h stop=%0b t=%0t", b, stop, $time);
    endtask

    task automatic send_seq(input logic [127:0] bv, input int n);
        for (int i = 0; i < n; i++) send_byte(bv[8*(n-1-i) +: 8], 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wr_count  = 0;
        done_rise = -1;
        cpu_rise  = -1;
        @(negedge clk);
    endtask

    initial begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        v[0] = '{128'hA5_02_00_05_00_08_20_0A_00_09_20_0C, 12, -1, 2, 64'h2009000A_20080005, 1'b1, 1'b0};
        v[1] = '{128'h00_FF_3C_A5_01_00_78_56_34_12_09,    11, -1, 1, 64'h00000000_12345678, 1'b1, 1'b0};
        v[2] = '{128'hA5_00_00_00,                          4, -1, 0, 64'h0,                 1'b1, 1'b0};
        v[5] = '{128'h7E_A5_00_00_00,                       5,  0, 0, 64'h0,                 1'b1, 1'b0};
        v[6] = '{128'hA5_01_00_78_56_34_12_00,              8, -1, 1, 64'h00000000_12345678, 1'b0, 1'b1};
`else
        v[0] = '{128'hA5_02_00_05_00_08_20_0A_00_09_20,    11, -1, 2, 64'h2009000A_20080005, 1'b1, 1'b0};
        v[1] = '{128'h00_FF_3C_A5_01_00_78_56_34_12,       10, -1, 1, 64'h00000000_12345678, 1'b1, 1'b0};
        v[2] = '{128'hA5_00_00,                             3, -1, 0, 64'h0,                 1'b1, 1'b0};
        v[5] = '{128'h7E_A5_00_00,                          4,  0, 0, 64'h0,                 1'b1, 1'b0};
`endif
        v[3] = '{128'hA5_01_01_A5_00_00,                    6, -1, 0, 64'h0,                 1'b0, 1'b1};
        v[4] = '{128'hA5_04_00_44_33_22_11_DD_CC_BB_AA_11, 12, 11, 2, 64'hAABBCCDD_11223344, 1'b0, 1'b1};

        // Reset state of every output.
        do_reset();
        chk("reset_outputs", {imem_we, imem_addr, imem_wdata, cpu_rst_n, load_busy, load_done, load_err}, 64'h0);

        // Table-driven frames.
        for (int k = 0; k < NV; k++) begin
            logic [127:0] bv;
            do_reset();
            bv = v[k].bytes;
            for (int i = 0; i < v[k].nbytes; i++)
                send_byte(bv[8*(v[k].nbytes-1-i) +: 8], (i == v[k].bad) ? 1'b0 : 1'b1);
            repeat (8) @(negedge clk);
            chk($sformatf("v%0d_writes", k), 64'(wr_count), 64'(v[k].nwr));
            for (int w = 0; w < v[k].nwr && w < 2; w++) begin
                chk($sformatf("v%0d_addr%0d", k, w), 64'(wr_addr[w]), 64'(w));
                chk($sformatf("v%0d_data%0d", k, w), 64'(wr_data[w]), 64'(v[k].words[32*w +: 32]));
            end
            chk($sformatf("v%0d_done", k), 64'(load_done), 64'(v[k].done));
            chk($sformatf("v%0d_err", k), 64'(load_err), 64'(v[k].err));
            chk($sformatf("v%0d_cpu_rst_n", k), 64'(cpu_rst_n), 64'(v[k].done));
            chk($sformatf("v%0d_busy", k), 64'(load_busy), 64'h0);
            if (v[k].done)
                chk($sformatf("v%0d_cpu_rst_delay", k), 64'(cpu_rise - done_rise), 64'd1);
            $display("vector %0d writes=%0d done=%0b err=%0b cpu_rst_n=%0b", k, wr_count, load_done, load_err, cpu_rst_n);
        end

        // Reset in the middle of a load, then a fresh load from address 0.
        do_reset();
        send_seq(128'hA5_04_00_44_33_22_11_DD_CC_BB_AA, 11);
        repeat (4) @(negedge clk);
        chk("mid_busy", 64'(load_busy), 64'h1);
        chk("mid_writes", 64'(wr_count), 64'd2);
        chk("hold_addr", 64'(imem_addr), 64'd1);
        chk("hold_data", 64'(imem_wdata), 64'hAABBCCDD);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midreset_outputs", {imem_we, imem_addr, imem_wdata, cpu_rst_n, load_busy, load_done, load_err}, 64'h0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_seq(128'hA5_01_00_78_56_34_12_09, 8);
`else
        send_seq(128'hA5_01_00_78_56_34_12, 7);
`endif
        repeat (8) @(negedge clk);
        chk("restart_writes", 64'(wr_count), 64'd3);
        chk("restart_addr", 64'(wr_addr[2]), 64'd0);
        chk("restart_data", 64'(wr_data[2]), 64'h12345678);
        chk("restart_done", 64'(load_done), 64'h1);
        $display("midreset restart writes=%0d done=%0b", wr_count, load_done);

        // Reload after DONE: header drops done and core reset, addresses restart.
        send_byte(8'hA5, 1'b1);
        repeat (4) @(negedge clk);
        chk("reload_done_low", 64'(load_done), 64'h0);
        chk("reload_cpu_low", 64'(cpu_rst_n), 64'h0);
        chk("reload_busy", 64'(load_busy), 64'h1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_seq(128'h01_00_EF_BE_AD_DE_23, 7);
`else
        send_seq(128'h01_00_EF_BE_AD_DE, 6);
`endif
        repeat (8) @(negedge clk);
        chk("reload_writes", 64'(wr_count), 64'd4);
        chk("reload_addr", 64'(wr_addr[3]), 64'd0);
        chk("reload_data", 64'(wr_data[3]), 64'hDEADBEEF);
        chk("reload_done", 64'(load_done), 64'h1);
        chk("reload_cpu", 64'(cpu_rst_n), 64'h1);
        $display("reload writes=%0d done=%0b cpu_rst_n=%0b", wr_count, load_done, cpu_rst_n);

        // One-cycle glitch low is a false start; the following header must still be seen.
        do_reset();
        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (6) @(negedge clk);
        send_byte(8'hA5, 1'b1);
        repeat (4) @(negedge clk);
        chk("glitch_busy", 64'(load_busy), 64'h1);
        chk("glitch_err", 64'(load_err), 64'h0);
        $display("glitch then header busy=%0b err=%0b", load_busy, load_err);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
